// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared types for the ID/EX operand stage.
//   XLEN        default datapath width
//   REG_ADDR_W  register index width
//   fwd_sel_e   which source feeds an EX operand
//   id_ex_t     index/flag fields of the ID/EX pipeline register
//               (the XLEN/CTRL_W-wide payload sits beside it in the top so
//               those widths can follow the module parameters)
//   reg_match   nonzero-register index compare used by hazard and forwarding logic
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EXM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_we;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } id_ex_t;

  // x0 is hardwired zero, so it never matches a producer.
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] producer,
                                     input logic [REG_ADDR_W-1:0] consumer);
    return (producer != '0) && (producer == consumer);
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux
//   Selects the EX value of one source operand: EX/MEM result, MEM/WB result,
//   or the value captured into ID/EX. EX/MEM is younger and wins.
// Ports
//   rs          in   source register index held in ID/EX
//   cap_val     in   operand captured at ID/EX load
//   exm_*       in   EX/MEM producer (valid, write enable, rd, data)
//   wb_*        in   MEM/WB write port (write enable, rd, data)
//   val         out  forwarded operand value
//   sel         out  source chosen for val
module operand_fwd_mux #(
  parameter int XLEN = 32
) (
  input  logic                 [4:0]      rs,
  input  logic                 [XLEN-1:0] cap_val,
  input  logic                            exm_valid,
  input  logic                            exm_rd_we,
  input  logic                 [4:0]      exm_rd,
  input  logic                 [XLEN-1:0] exm_data,
  input  logic                            wb_we,
  input  logic                 [4:0]      wb_rd,
  input  logic                 [XLEN-1:0] wb_data,
  output logic                 [XLEN-1:0] val,
  output riscv_pkg::fwd_sel_e             sel
);
  import riscv_pkg::*;

  always_comb begin
    sel = FWD_NONE;
    if (exm_valid && exm_rd_we && reg_match(exm_rd, rs)) begin
      sel = FWD_EXM;
    end else if (wb_we && reg_match(wb_rd, rs)) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    case (sel)
      FWD_EXM: val = exm_data;
      FWD_WB:  val = wb_data;
      default: val = cap_val;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   Decode-to-execute operand stage. Drives regfile read addresses, captures
//   read data into the ID/EX register, forwards EX/MEM and MEM/WB results into
//   the EX operands, inserts a bubble on load-use hazards and applies
//   ex_stall backpressure and flush.
// Configuration macro: OPSTAGE_WB_BYPASS_EN
//   defined   : a same-cycle MEM/WB write to a source register is captured
//               directly (write-before-read bypass), no stall.
//   undefined : such a collision inserts a one-cycle bubble; ID retries once the
//               regfile holds the new value.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   id_*                         instruction in ID (valid, pc, rs1/rs2 + used, rd + we, is_load, ctrl)
//   rf_rs1_addr/rf_rs2_addr      regfile read addresses (= id_rs1/id_rs2)
//   rf_rs1_data/rf_rs2_data      regfile combinational read data
//   exm_valid/rd_we/rd/data      EX/MEM ALU result
//   wb_we/wb_rd/wb_data          MEM/WB write port
//   ex_stall, flush              EX backpressure, kill of the entering instruction
//   id_stall                     hold IF/ID this cycle
//   ex_valid/pc/rd/rd_we/is_load/ctrl  registered ID/EX contents
//   ex_rs1_val/ex_rs2_val        forwarded EX operands
module id_ex_operand_stage #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [4:0]        id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [4:0]        rf_rs1_addr,
  output logic [4:0]        rf_rs2_addr,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,
  input  logic              exm_valid,
  input  logic              exm_rd_we,
  input  logic [4:0]        exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_rd,
  output logic              ex_rd_we,
  output logic              ex_is_load,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val
);
  import riscv_pkg::*;

  id_ex_t            ex_reg, ex_next;
  logic [XLEN-1:0]   pc_reg, pc_next;
  logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
  logic [XLEN-1:0]   rs1_cap_reg, rs1_cap_next;
  logic [XLEN-1:0]   rs2_cap_reg, rs2_cap_next;
  logic [XLEN-1:0]   cap1, cap2;
  logic              lu, wb_hz;

  assign rf_rs1_addr = id_rs1;
  assign rf_rs2_addr = id_rs2;

  // Load data is not available until after MEM, so a dependent instruction
  // in ID must wait one cycle and then pick the value up from MEM/WB.
  assign lu = ex_reg.valid & ex_reg.is_load & ex_reg.rd_we & id_valid &
              ((id_rs1_used & reg_match(ex_reg.rd, id_rs1)) |
               (id_rs2_used & reg_match(ex_reg.rd, id_rs2)));

`ifdef OPSTAGE_WB_BYPASS_EN
  assign wb_hz = 1'b0;
  assign cap1  = (wb_we && reg_match(wb_rd, id_rs1)) ? wb_data : rf_rs1_data;
  assign cap2  = (wb_we && reg_match(wb_rd, id_rs2)) ? wb_data : rf_rs2_data;
`else
  // Regfile read returns the pre-write value this cycle; retry next cycle.
  assign wb_hz = id_valid & wb_we &
                 ((id_rs1_used & reg_match(wb_rd, id_rs1)) |
                  (id_rs2_used & reg_match(wb_rd, id_rs2)));
  assign cap1  = rf_rs1_data;
  assign cap2  = rf_rs2_data;
`endif

  assign id_stall = ex_stall | lu | wb_hz;

  // Priority: flush, then hold on ex_stall, then bubble, then load.
  always_comb begin
    ex_next      = ex_reg;
    pc_next      = pc_reg;
    ctrl_next    = ctrl_reg;
    rs1_cap_next = rs1_cap_reg;
    rs2_cap_next = rs2_cap_reg;
    if (flush) begin
      ex_next.valid = 1'b0;
    end else if (!ex_stall) begin
      if (lu || wb_hz) begin
        ex_next.valid   = 1'b0;
        ex_next.rd_we   = 1'b0;
        ex_next.is_load = 1'b0;
      end else begin
        ex_next.valid   = id_valid;
        ex_next.rd      = id_rd;
        ex_next.rd_we   = id_rd_we;
        ex_next.is_load = id_is_load;
        ex_next.rs1     = id_rs1;
        ex_next.rs2     = id_rs2;
        pc_next         = id_pc;
        ctrl_next       = id_ctrl;
        rs1_cap_next    = cap1;
        rs2_cap_next    = cap2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg      <= '0;
      pc_reg      <= '0;
      ctrl_reg    <= '0;
      rs1_cap_reg <= '0;
      rs2_cap_reg <= '0;
    end else begin
      ex_reg      <= ex_next;
      pc_reg      <= pc_next;
      ctrl_reg    <= ctrl_next;
      rs1_cap_reg <= rs1_cap_next;
      rs2_cap_reg <= rs2_cap_next;
    end
  end

  // Forwarding is combinational on the held ID/EX contents, so an instruction
  // held by ex_stall keeps picking up producers as they drain.
  logic [4:0]      fwd_rs  [2];
  logic [XLEN-1:0] fwd_cap [2];
  logic [XLEN-1:0] fwd_val [2];
  fwd_sel_e        fwd_sel [2];

  assign fwd_rs[0]  = ex_reg.rs1;
  assign fwd_rs[1]  = ex_reg.rs2;
  assign fwd_cap[0] = rs1_cap_reg;
  assign fwd_cap[1] = rs2_cap_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    operand_fwd_mux #(.XLEN(XLEN)) u_mux (
      .rs        (fwd_rs[gi]),
      .cap_val   (fwd_cap[gi]),
      .exm_valid (exm_valid),
      .exm_rd_we (exm_rd_we),
      .exm_rd    (exm_rd),
      .exm_data  (exm_data),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .val       (fwd_val[gi]),
      .sel       (fwd_sel[gi])
    );
  end

  // Selects are kept as named nets for waveform debug only.
  logic unused_fwd_sel;
  assign unused_fwd_sel = ^{fwd_sel[0], fwd_sel[1]};

  assign ex_rs1_val = fwd_val[0];
  assign ex_rs2_val = fwd_val[1];
  assign ex_valid   = ex_reg.valid;
  assign ex_pc      = pc_reg;
  assign ex_rd      = ex_reg.rd;
  assign ex_rd_we   = ex_reg.rd_we;
  assign ex_is_load = ex_reg.is_load;
  assign ex_ctrl    = ctrl_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage
//   Directed bench for id_ex_operand_stage. A small regfile model answers the
//   read ports; expected EX contents are queued when an instruction is driven
//   into ID and popped when it appears in EX.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
  logic [15:0] id_ctrl;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        exm_valid, exm_rd_we;
  logic [4:0]  exm_rd;
  logic [31:0] exm_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_stall, flush;
  logic        id_stall, ex_valid, ex_rd_we, ex_is_load;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val;
  logic [4:0]  ex_rd;
  logic [15:0] ex_ctrl;

  id_ex_operand_stage #(.XLEN(32), .CTRL_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_ctrl(id_ctrl),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .exm_valid(exm_valid), .exm_rd_we(exm_rd_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val)
  );

  always #5 clk = ~clk;

  // Regfile model: initial contents loaded under reset, written by the WB port.
  function automatic logic [31:0] rfv(input int i);
    return (i == 0) ? 32'h0 : (32'hA000_0000 | i);
  endfunction

  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= rfv(i);
    end else if (wb_we && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end
  assign rf_rs1_data = rf[rf_rs1_addr];
  assign rf_rs2_data = rf[rf_rs2_addr];

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_load;
    logic [15:0] ctrl;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    exm_valid = 1'b0; exm_rd_we = 1'b0; exm_rd = 5'd0; exm_data = 32'h0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic we, input logic ld, input logic [15:0] ctrl);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2;
    id_rs1_used = u1; id_rs2_used = u2; id_rd = rd; id_rd_we = we;
    id_is_load = ld; id_ctrl = ctrl;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                          input logic ld, input logic [15:0] ctrl,
                          input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    e.pc = pc; e.rd = rd; e.rd_we = we; e.is_load = ld; e.ctrl = ctrl; e.rs1 = r1; e.rs2 = r2;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty queue expected one entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'h0, ex_valid}, 32'h1);
      chk({tag, "_pc"}, ex_pc, e.pc);
      chk({tag, "_rd"}, {27'h0, ex_rd}, {27'h0, e.rd});
      chk({tag, "_rd_we"}, {31'h0, ex_rd_we}, {31'h0, e.rd_we});
      chk({tag, "_is_load"}, {31'h0, ex_is_load}, {31'h0, e.is_load});
      chk({tag, "_ctrl"}, {16'h0, ex_ctrl}, {16'h0, e.ctrl});
      chk({tag, "_rs1"}, ex_rs1_val, e.rs1);
      chk({tag, "_rs2"}, ex_rs2_val, e.rs2);
      $display("txn %s: pc=%h rd=%0d rs1_val=%h rs2_val=%h", tag, ex_pc, ex_rd, ex_rs1_val, ex_rs2_val);
    end
  endtask

  initial begin
    // Reset with a valid instruction presented in ID.
    rst = 1'b1; ex_stall = 1'b0; flush = 1'b0;
    clear_fwd();
    drive_id(32'h40, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 16'hFFFF);
    tick(); tick();
    rst = 1'b0; id_valid = 1'b0;
    #1;
    chk("rst_ex_valid", {31'h0, ex_valid}, 32'h0);
    chk("rst_ex_rd_we", {31'h0, ex_rd_we}, 32'h0);
    chk("rst_ex_is_load", {31'h0, ex_is_load}, 32'h0);
    chk("rst_id_stall", {31'h0, id_stall}, 32'h0);
    chk("rst_rs1_val", ex_rs1_val, 32'h0);

    // ALU chain: add x5,x1,x2 ; sub x6,x5,x1 with x5 coming from EX/MEM.
    drive_id(32'h100, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 16'h0011);
    #1;
    chk("add_id_stall", {31'h0, id_stall}, 32'h0);
    push_exp(32'h100, 5'd5, 1'b1, 1'b0, 16'h0011, rfv(1), rfv(2));
    tick();
    drive_id(32'h104, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 16'h0022);
    #1;
    pop_check("add");
    push_exp(32'h104, 5'd6, 1'b1, 1'b0, 16'h0022, 32'h1234, rfv(1));
    tick();
    id_valid = 1'b0;
    exm_valid = 1'b1; exm_rd_we = 1'b1; exm_rd = 5'd5; exm_data = 32'h1234;
    #1;
    pop_check("sub");

    // Priority: EX/MEM beats MEM/WB for the same register.
    tick();
    clear_fwd();
    drive_id(32'h108, 5'd7, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 16'h0033);
    push_exp(32'h108, 5'd8, 1'b1, 1'b0, 16'h0033, 32'hA, 32'h0);
    tick();
    id_valid = 1'b0;
    exm_valid = 1'b1; exm_rd_we = 1'b1; exm_rd = 5'd7; exm_data = 32'hA;
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hB;
    #1;
    pop_check("prio_exm");
    tick();  // x7 <= 0xB in the regfile

    // x0 is never forwarded even when producers target it.
    clear_fwd();
    drive_id(32'h10C, 5'd0, 5'd7, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 16'h0044);
    push_exp(32'h10C, 5'd9, 1'b1, 1'b0, 16'h0044, 32'h0, 32'hB);
    tick();
    id_valid = 1'b0;
    exm_valid = 1'b1; exm_rd_we = 1'b1; exm_rd = 5'd0; exm_data = 32'hDEAD;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hBEEF;
    #1;
    pop_check("x0");

    // Load-use: lw x3 in EX, add x4,x3,x3 in ID.
    tick();
    clear_fwd();
    drive_id(32'h110, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 16'h0055);
    push_exp(32'h110, 5'd3, 1'b1, 1'b1, 16'h0055, rfv(1), 32'h0);
    tick();
    drive_id(32'h114, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 16'h0066);
    #1;
    chk("lu_id_stall", {31'h0, id_stall}, 32'h1);
    pop_check("lw");
    tick();
    chk("lu_bubble_valid", {31'h0, ex_valid}, 32'h0);
    chk("lu_bubble_is_load", {31'h0, ex_is_load}, 32'h0);
    chk("lu_after_id_stall", {31'h0, id_stall}, 32'h0);
    push_exp(32'h114, 5'd4, 1'b1, 1'b0, 16'h0066, 32'h77, 32'h77);
    tick();
    id_valid = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h77;
    #1;
    pop_check("add_lu");

    // ex_stall holds ID/EX for three cycles while forwarding stays live.
    tick();
    clear_fwd();
    drive_id(32'h120, 5'd10, 5'd11, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 16'h0077);
    push_exp(32'h120, 5'd12, 1'b1, 1'b0, 16'h0077, rfv(10), rfv(11));
    tick();
    drive_id(32'h124, 5'd13, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 16'h0088);
    ex_stall = 1'b1;
    #1;
    pop_check("pre_stall");
    chk("stall_id_stall", {31'h0, id_stall}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) begin
        exm_valid = 1'b1; exm_rd_we = 1'b1; exm_rd = 5'd10; exm_data = 32'h99;
      end else begin
        clear_fwd();
      end
      #1;
      chk($sformatf("stall%0d_valid", i), {31'h0, ex_valid}, 32'h1);
      chk($sformatf("stall%0d_pc", i), ex_pc, 32'h120);
      chk($sformatf("stall%0d_id_stall", i), {31'h0, id_stall}, 32'h1);
      chk($sformatf("stall%0d_rs1", i), ex_rs1_val, (i == 1) ? 32'h99 : rfv(10));
      $display("txn stall%0d: pc=%h rs1_val=%h id_stall=%b", i, ex_pc, ex_rs1_val, id_stall);
    end
    flush = 1'b1;  // flush wins over ex_stall
    tick();
    flush = 1'b0; ex_stall = 1'b0;
    #1;
    chk("flush_valid", {31'h0, ex_valid}, 32'h0);
    chk("flush_id_stall", {31'h0, id_stall}, 32'h0);
    push_exp(32'h124, 5'd14, 1'b1, 1'b0, 16'h0088, rfv(13), 32'h0);
    tick();
    id_valid = 1'b0;
    #1;
    pop_check("after_flush");

    // Same-cycle MEM/WB write to a register being read in ID.
    tick();
    clear_fwd();
    drive_id(32'h130, 5'd9, 5'd0, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0, 16'h0099);
    wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
    #1;
`ifdef OPSTAGE_WB_BYPASS_EN
    chk("byp_id_stall", {31'h0, id_stall}, 32'h0);
    push_exp(32'h130, 5'd15, 1'b1, 1'b0, 16'h0099, 32'h55, 32'h0);
    tick();
    clear_fwd();
    id_valid = 1'b0;
    #1;
    pop_check("bypass");
`else
    chk("byp_id_stall", {31'h0, id_stall}, 32'h1);
    tick();
    clear_fwd();
    #1;
    chk("byp_bubble_valid", {31'h0, ex_valid}, 32'h0);
    chk("byp_retry_id_stall", {31'h0, id_stall}, 32'h0);
    push_exp(32'h130, 5'd15, 1'b1, 1'b0, 16'h0099, 32'h55, 32'h0);
    tick();
    id_valid = 1'b0;
    #1;
    pop_check("bypass");
`endif

    // Reset in the middle of a stall discards the held instruction.
    tick();
    clear_fwd();
    drive_id(32'h140, 5'd1, 5'd2, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 16'h00AA);
    push_exp(32'h140, 5'd16, 1'b1, 1'b0, 16'h00AA, rfv(1), rfv(2));
    tick();
    ex_stall = 1'b1;
    #1;
    pop_check("pre_rst");
    rst = 1'b1;
    tick();
    rst = 1'b0; ex_stall = 1'b0; id_valid = 1'b0;
    #1;
    chk("midrst_valid", {31'h0, ex_valid}, 32'h0);
    chk("midrst_pc", ex_pc, 32'h0);
    chk("midrst_rs1", ex_rs1_val, 32'h0);
    chk("sb_empty", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
